// File: rtl/dat_mem_p.sv
// dat_mem_p: DEPTH = 2**AW words of DW bits with one clocked write port,
// one read port, two fixed-address watch taps and a clear sequencer that
// zeroes every word after reset.
//
// Build option: define DAT_MEM_P_REG_RD_EN to register dat_out (1-cycle
// read latency, register resets to 0). Left undefined, dat_out is a purely
// combinational function of the current inputs and memory contents.
//
// Handshake: there is no valid/ready pair here. busy=1 means the clear sweep
// owns the array; reads return 0, writes are silently dropped, and the
// controller is expected to stall. busy=0 means every cycle is a legal
// access, and a write is committed on the edge where wr_en=1.
//
// state_dbg exposes the sweep FSM state (0 = CLEAR, 1 = RUN).
module dat_mem_p #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int WATCH0 = 64,
  parameter int WATCH1 = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          Memread,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  output logic [DW-1:0] track0,
  output logic [DW-1:0] track1,
  output logic          busy,
  output logic          state_dbg
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] W0_IDX = AW'(WATCH0);
  localparam logic [AW-1:0] W1_IDX = AW'(WATCH1);

  // Watch addresses outside the array are a configuration error.
  if (WATCH0 >= DEPTH || WATCH1 >= DEPTH || WATCH0 < 0 || WATCH1 < 0) begin : g_watch_range_bad
    $error("dat_mem_p: WATCH0/WATCH1 must lie in 0..DEPTH-1");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [DW-1:0] core [DEPTH];
  logic [DW-1:0] rd_comb;

  // Sweep state register; reset restarts the sweep at word 0 from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state: walk clr_ptr across the array, leave CLEAR after the last word.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        clr_ptr_d = clr_ptr_q;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Array write port: the sweep owns it in CLEAR, the store path in RUN.
  // Nothing is written on a reset edge; the sweep begins on the next edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        core[clr_ptr_q] <= '0;
      end else if (wr_en) begin
        core[addr] <= dat_in;
      end
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign state_dbg = state_q;

  // Read or pass-through value; memory reads as 0 while the sweep runs.
  always_comb begin
    rd_comb = dat_in;
    if (Memread) rd_comb = busy ? '0 : core[addr];
  end

  assign track0 = busy ? '0 : core[W0_IDX];
  assign track1 = busy ? '0 : core[W1_IDX];

`ifdef DAT_MEM_P_REG_RD_EN
  logic [DW-1:0] dat_out_q;

  // Registered read: captures the pre-edge value, so reads are read-before-write.
  always_ff @(posedge clk) begin
    if (reset) dat_out_q <= '0;
    else       dat_out_q <= rd_comb;
  end

  assign dat_out = dat_out_q;
`else
  assign dat_out = rd_comb;
`endif

endmodule

// File: doc/dat_mem_p.md
# dat_mem_p

Parametrised data memory: `DEPTH = 2**AW` words of `DW` bits, with a combinational or registered read port, a clocked write port, two parametrised watch taps and a hardware clear sequencer. On reset the clear sequencer zeroes every word before normal access resumes. The block is the data-memory stage of the processor datapath, between the ALU/address path and the register write-back mux. Loads, stores and the debug watch taps all go through it.

## Interface
- `DW`, default 8: data word width in bits.
- `AW`, default 8: address width in bits; `DEPTH = 2**AW`.
- `WATCH0`, default 64: word address driven on `track0`.
- `WATCH1`, default 65: word address driven on `track1`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset; starts a clear sweep.
- `wr_en`  in  1  write enable for the store path.
- `Memread`  in  1  1: `dat_out` returns memory data; 0: `dat_out` passes `dat_in` through.
- `addr`  in  AW  word address for read and write.
- `dat_in`  in  DW  write data and pass-through data.
- `dat_out`  out  DW  read data or pass-through.
- `track0`, `track1`  out  DW  live contents of `core[WATCH0]` and `core[WATCH1]`.
- `busy`  out  1  high while the clear sweep runs; the controller stalls on it.

## Operation
- **States**
  - CLEAR: sweep in progress, `busy`=1.
  - RUN: normal access, `busy`=0.
- **Reset**
  - A rising edge with `reset`=1 sets state=CLEAR and `clr_ptr`=0.
  - This applies from any state, including partway through a sweep, which restarts it at word 0.
- **CLEAR**
  - Each edge with `reset`=0 writes `core[clr_ptr]` <= 0 and increments `clr_ptr` (AW bits wide).
  - On the edge that writes word DEPTH-1, the next state is RUN. `clr_ptr` wraps to 0 and is unused in RUN.
  - `wr_en` is ignored; user writes are dropped, not queued.
  - With `Memread`=1, `dat_out` = 0. With `Memread`=0, `dat_out` = `dat_in`.
  - `track0` and `track1` = 0.
- **RUN**
  - An edge with `wr_en`=1 writes `core[addr]` <= `dat_in`.
  - `dat_out` = `Memread` ? `core[addr]` : `dat_in`.
  - `track0` and `track1` follow their words combinationally.
- `WATCH0` and `WATCH1` must be < DEPTH. This is checked by an elaboration-time assertion.
- Contents before the first reset are undefined. Outputs are undefined until the first reset edge.

## Timing
- **Reset values** (after the reset edge):
  - `busy`=1.
  - `track0` and `track1` = 0.
  - Registered mode: `dat_out`=0.
  - Combinational mode: `dat_out` = `Memread` ? 0 : `dat_in`.
- **Clear duration:** `busy` stays high for exactly DEPTH cycles after the last reset edge (256 for AW=8), then falls. The first user write is accepted on the next edge.
- **Reset held high:** `clr_ptr` holds at 0 and the DEPTH-cycle count starts only from the first low-reset edge.
- **Write latency:** 1 edge. In combinational mode, a read of the same address in the following cycle returns the new data.
- **Read-during-write, same address, same cycle:**
  - Combinational mode: `dat_out` shows old data before the edge and new data after it.
  - Registered mode: read-before-write; the registered output captures the old data.
- **Watch taps:** combinational from `core` and update in the cycle after the write edge.

## Configuration
- Macro: `DAT_MEM_P_REG_RD_EN`.
- **Defined:**
  - `dat_out` is a register loaded every edge with the combinational value above, so it has 1-cycle latency.
  - The register resets to 0.
  - Read data captured in the last CLEAR cycle is 0.
- **Undefined:** `dat_out` is purely combinational, with 0-cycle latency.
- Write path, watch taps and `busy` are identical in both builds.

## Test plan
- **Clear sweep:** preload `core[5]`=8'hA5, assert `reset` for 1 edge, count `busy` cycles.
  - `busy` stays high for exactly 256 cycles.
  - Then `Memread`=1, `addr`=5 gives `dat_out`=8'h00.
  - `core[255]`=0.
- **Store/load:** in RUN, write 8'h3C to address 64 and 8'hC3 to address 65.
  - `track0`=8'h3C and `track1`=8'hC3 the next cycle.
  - Reading address 64 gives 8'h3C: same cycle after the edge when combinational, one cycle later with `DAT_MEM_P_REG_RD_EN`.
- **Pass-through:** `Memread`=0, `dat_in`=8'h77, `wr_en`=0.
  - `dat_out`=8'h77, with one-cycle delay in registered mode.
  - Memory is unchanged.
- **Write during busy:** one cycle after reset, `wr_en`=1, `addr`=10, `dat_in`=8'hFF.
  - After `busy` falls, `core[10]`=0.
- **Reset mid-sweep:** assert `reset` at sweep cycle 100.
  - `busy` stays high for a further 256 cycles counted from that reset edge.
  - Every word reads 0 afterwards.
- **Read-before-write (`DAT_MEM_P_REG_RD_EN`):** `core[7]`=8'h11; in one cycle, write 8'h22 and read address 7.
  - `dat_out`=8'h11 next cycle.
  - `dat_out`=8'h22 the cycle after.
